// File: rtl/fb_port_b_arbiter.sv
// fb_port_b_arbiter: shares frame-buffer RAM read port B between the
// display prefetch FIFO and an auxiliary reader, display urgent below LOW_WM.
module fb_port_b_arbiter #(
  parameter int AW      = 18,
  parameter int DW      = 24,
  parameter int RD_LAT  = 2,
  parameter int FIFO_D  = 8,
  parameter int LOW_WM  = 3,
  parameter int FRAME_W = 76800
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          pix_rd,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  output logic          pix_underrun,
  input  logic          aux_req,
  input  logic [AW-1:0] aux_addr,
  output logic          aux_ack,
  output logic          aux_rvalid,
  output logic [DW-1:0] aux_rdata,
  output logic [AW-1:0] address_b,
  input  logic [DW-1:0] read_data_b
);

  localparam int PW = $clog2(FIFO_D);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(RD_LAT + 1);
  localparam int LW = $clog2(FIFO_D + RD_LAT + 1) + 1;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    RUN
  } state_e;

  state_e            state_q;
  logic [AW-1:0]     disp_addr_q;
  logic [AW-1:0]     disp_addr_d;
  logic [AW-1:0]     addr_q;
  logic [RD_LAT-1:0] tag_v_q;
  logic [RD_LAT-1:0] tag_aux_q;
  logic [DW-1:0]     fifo_q [FIFO_D];
  logic [PW-1:0]     wptr_q;
  logic [PW-1:0]     rptr_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              underrun_q;
  logic              underrun_d;

  logic [IW-1:0] disp_inflight;
  logic [LW-1:0] level;
  logic          disp_ok;
  logic          urgent;
  logic          issue_disp;
  logic          issue_aux;
  logic          tail_v;
  logic          tail_aux;
  logic          flush;
  logic          push;
  logic          pop;

  always_comb begin
    disp_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      if (tag_v_q[i] && !tag_aux_q[i]) begin
        disp_inflight = disp_inflight + IW'(1);
      end
    end
  end

  // Level counts reads already issued, so the FIFO can never overflow.
  always_comb begin
    level      = LW'(cnt_q) + LW'(disp_inflight);
    disp_ok    = (state_q == RUN) && !frame_start
                 && (level < LW'(FIFO_D));
    urgent     = disp_ok && (level < LW'(LOW_WM));
    issue_disp = urgent || (disp_ok && !aux_req);
    issue_aux  = aux_req && !urgent;
  end

  always_comb begin
    tail_v   = tag_v_q[RD_LAT-1];
    tail_aux = tag_aux_q[RD_LAT-1];
    flush    = frame_start || (state_q != RUN);
    push     = tail_v && !tail_aux && !flush;
    pop      = pix_rd && (cnt_q != '0) && !frame_start;
  end

  always_comb begin
    disp_addr_d = disp_addr_q;
    if (frame_start) begin
      disp_addr_d = '0;
    end else if (issue_disp) begin
      if (disp_addr_q == AW'(FRAME_W - 1)) begin
        disp_addr_d = '0;
      end else begin
        disp_addr_d = disp_addr_q + AW'(1);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    underrun_d = underrun_q;
    if (frame_start) begin
      underrun_d = 1'b0;
    end else if (pix_rd && (cnt_q == '0)) begin
      underrun_d = 1'b1;
    end
  end

  always_comb begin
    address_b = addr_q;
    unique case (1'b1)
      issue_disp: address_b = disp_addr_q;
      issue_aux:  address_b = aux_addr;
      default:    address_b = addr_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      disp_addr_q <= '0;
      addr_q      <= '0;
      tag_v_q     <= '0;
      tag_aux_q   <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      underrun_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (frame_start) state_q <= FLUSH;
        end
        FLUSH: begin
          if (!frame_start && disp_inflight == '0)
            state_q <= RUN;
        end
        RUN: begin
          if (frame_start) state_q <= FLUSH;
        end
        default: state_q <= IDLE;
      endcase
      disp_addr_q <= disp_addr_d;
      addr_q      <= address_b;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_aux_q[i] <= tag_aux_q[i-1];
      end
      tag_v_q[0]   <= issue_disp || issue_aux;
      tag_aux_q[0] <= issue_aux && !issue_disp;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + PW'(1);
        if (pop)  rptr_q <= rptr_q + PW'(1);
      end
      cnt_q      <= cnt_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= read_data_b;
  end

  assign pix_valid    = (cnt_q != '0);
  assign pix_data     = pix_valid ? fifo_q[rptr_q] : '0;
  assign pix_underrun = underrun_q;
  assign aux_ack      = issue_aux && !issue_disp;
  assign aux_rvalid   = tail_v && tail_aux;
  assign aux_rdata    = aux_rvalid ? read_data_b : '0;

endmodule

// File: tb/tb_fb_port_b_arbiter.sv
// tb_fb_port_b_arbiter: directed and random checks of the port-B arbiter
// against a pixel-sequence and aux-latency reference model.
module tb_fb_port_b_arbiter;

  localparam int AW      = 18;
  localparam int DW      = 24;
  localparam int RD_LAT  = 2;
  localparam int FIFO_D  = 8;
  localparam int LOW_WM  = 3;
  localparam int FRAME_W = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          pix_rd;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_underrun;
  logic          aux_req;
  logic [AW-1:0] aux_addr;
  logic          aux_ack;
  logic          aux_rvalid;
  logic [DW-1:0] aux_rdata;
  logic [AW-1:0] address_b;
  logic [DW-1:0] read_data_b;

  fb_port_b_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D),
    .LOW_WM(LOW_WM), .FRAME_W(FRAME_W)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .pix_rd(pix_rd), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_underrun(pix_underrun), .aux_req(aux_req),
    .aux_addr(aux_addr), .aux_ack(aux_ack),
    .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .address_b(address_b), .read_data_b(read_data_b)
  );

  always #5 clk = ~clk;

  // RAM model: mem[a] = a with RD_LAT cycles of latency.
  logic [DW-1:0] rpipe [RD_LAT];
  always_ff @(posedge clk) begin
    rpipe[0] <= DW'(address_b);
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign read_data_b = rpipe[RD_LAT-1];

  int unsigned   n_chk  = 0;
  int unsigned   n_pass = 0;
  int unsigned   cyc_n  = 0;
  int unsigned   exp_pix = 0;
  logic          acked = 1'b0;
  logic [AW-1:0] aq_addr [$];
  int unsigned   aq_due  [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
  endtask

  task automatic tick();
    logic exp_rv;
    @(negedge clk);
    acked = aux_ack;
    if (aux_ack) begin
      chk("ack_with_req", 32'(aux_req), 32'd1);
      chk("ack_addr", 32'(address_b), 32'(aux_addr));
      aq_addr.push_back(aux_addr);
      aq_due.push_back(cyc_n + RD_LAT);
    end
    exp_rv = (aq_due.size() != 0) && (aq_due[0] == cyc_n);
    if (aq_due.size() != 0 || aux_rvalid)
      chk("aux_rvalid", 32'(aux_rvalid), 32'(exp_rv));
    if (exp_rv) begin
      chk("aux_rdata", 32'(aux_rdata), 32'(aq_addr[0]));
      void'(aq_addr.pop_front());
      void'(aq_due.pop_front());
    end else if (aq_due.size() != 0 && aq_due[0] < cyc_n) begin
      void'(aq_addr.pop_front());
      void'(aq_due.pop_front());
    end
    if (pix_rd && pix_valid && !frame_start) begin
      chk("pix_data", 32'(pix_data), exp_pix);
      exp_pix = (exp_pix + 1) % FRAME_W;
    end
    if (frame_start) exp_pix = 0;
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_addr1();
    bit seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      if (address_b == AW'(1)) seen = 1'b1;
      else tick();
    end
    chk("wait_addr1", 32'(address_b), 32'd1);
  endtask

  initial begin
    int wait_n;
    rst = 1'b0; frame_start = 1'b0; pix_rd = 1'b0;
    aux_req = 1'b0; aux_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_address_b", 32'(address_b), 32'd0);
    chk("rst_aux_ack", 32'(aux_ack), 32'd0);
    chk("rst_aux_rvalid", 32'(aux_rvalid), 32'd0);
    chk("rst_aux_rdata", 32'(aux_rdata), 32'd0);
    chk("rst_underrun", 32'(pix_underrun), 32'd0);
    rst = 1'b1;
    tick();

    // fill: 8 issues at 0..7 then stall
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (20) tick();
    chk("fill_valid", 32'(pix_valid), 32'd1);
    chk("fill_head", 32'(pix_data), 32'd0);
    chk("fill_last_addr", 32'(address_b), 32'd7);
    repeat (3) tick();
    chk("fill_stall_addr", 32'(address_b), 32'd7);

    // continuous pop across the frame wrap
    pix_rd = 1'b1;
    repeat (FRAME_W + 10) begin
      chk("stream_valid", 32'(pix_valid), 32'd1);
      tick();
    end
    pix_rd = 1'b0;
    chk("stream_underrun", 32'(pix_underrun), 32'd0);
    repeat (10) tick();

    // aux read with a full FIFO
    aux_req = 1'b1; aux_addr = 18'h01234;
    #1 chk("aux_full_ack", 32'(aux_ack), 32'd1);
    tick(); aux_req = 1'b0;
    #1 chk("aux_rv_early", 32'(aux_rvalid), 32'd0);
    tick();
    #1 chk("aux_rv_lat", 32'(aux_rvalid), 32'd1);
    chk("aux_rd_1234", 32'(aux_rdata), 32'h1234);
    tick();

    // display urgent below LOW_WM beats aux
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    wait_addr1();
    tick();
    aux_req = 1'b1; aux_addr = 18'h2AAAA;
    #1 chk("urgent_no_ack", 32'(aux_ack), 32'd0);
    chk("urgent_disp_addr", 32'(address_b), 32'd2);
    tick();
    #1 chk("wm_ack", 32'(aux_ack), 32'd1);
    chk("wm_aux_addr", 32'(address_b), 32'h2AAAA);
    tick(); aux_req = 1'b0;
    repeat (12) tick();

    // frame_start with two display reads in flight
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    wait_addr1();
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    #1 chk("flush_empty", 32'(pix_valid), 32'd0);
    tick();
    chk("flush_empty2", 32'(pix_valid), 32'd0);
    for (int i = 0; i < 16 && !pix_valid; i++) tick();
    chk("refill_valid", 32'(pix_valid), 32'd1);
    chk("refill_head", 32'(pix_data), 32'd0);
    pix_rd = 1'b1; repeat (3) tick(); pix_rd = 1'b0;
    repeat (10) tick();

    // pop coinciding with frame_start: flush wins
    pix_rd = 1'b1; frame_start = 1'b1; tick();
    pix_rd = 1'b0; frame_start = 1'b0;
    #1 chk("fs_pop_empty", 32'(pix_valid), 32'd0);
    chk("fs_pop_no_under", 32'(pix_underrun), 32'd0);

    // underrun is sticky until frame_start
    pix_rd = 1'b1;
    #1 chk("under_pre_empty", 32'(pix_valid), 32'd0);
    tick(); pix_rd = 1'b0;
    #1 chk("under_set", 32'(pix_underrun), 32'd1);
    repeat (15) tick();
    chk("under_sticky", 32'(pix_underrun), 32'd1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    #1 chk("under_clear", 32'(pix_underrun), 32'd0);
    repeat (12) tick();

    // reset in the middle of an aux read
    aux_req = 1'b1; aux_addr = 18'h3F0F0;
    #1 chk("rst_aux_ack_pre", 32'(aux_ack), 32'd1);
    tick(); aux_req = 1'b0;
    #1 rst = 1'b0;
    aq_addr.delete(); aq_due.delete();
    #1 chk("arst_valid", 32'(pix_valid), 32'd0);
    chk("arst_addr", 32'(address_b), 32'd0);
    chk("arst_rvalid", 32'(aux_rvalid), 32'd0);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < RD_LAT + 3; i++) begin
      chk("post_rst_rvalid", 32'(aux_rvalid), 32'd0);
      tick();
    end

    // random traffic against the model
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    wait_n = 0;
    for (int c = 0; c < 3000; c++) begin
      frame_start = ($urandom_range(0, 399) == 0);
      pix_rd = pix_valid && ($urandom_range(0, 9) < 6);
      if (!aux_req && $urandom_range(0, 4) == 0) begin
        aux_req = 1'b1;
        aux_addr = AW'($urandom);
        wait_n = 0;
      end
      tick();
      if (aux_req) begin
        if (acked) begin
          aux_req = 1'b0;
        end else begin
          wait_n++;
          if (wait_n > 60) begin
            chk("aux_timeout", 32'(wait_n), 32'd60);
            aux_req = 1'b0;
          end
        end
      end
    end
    frame_start = 1'b0; pix_rd = 1'b0; aux_req = 1'b0;
    repeat (RD_LAT + 2) tick();
    chk("rand_underrun", 32'(pix_underrun), 32'd0);
    chk("rand_aux_drained", aq_due.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
